// File: rtl/result_display_pkg.sv
// Shared types and constants for the result_display block: FSM states,
// active-low 7-segment codes and the blanking threshold.
package result_display_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

    localparam int unsigned BLANK_CODE   = 200;
    localparam int unsigned SHIFT_CYCLES = 8;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    // Indexed by BCD digit; element 0 is the rightmost entry.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

endpackage

// File: rtl/result_display_seg7_decode.sv
// Combinational BCD digit to active-low 7-segment (gfedcba) decoder.
// Non-decimal codes produce a blank digit.
module seg7_decode
    import result_display_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (digit_i < 4'd10) begin
            seg_o = SEG_TABLE[digit_i];
        end
    end

endmodule

// File: rtl/result_display.sv
// Resynchronises the ALU signed-magnitude result, converts it to BCD by
// double-dabble and drives sign/hundreds/tens/units displays.
// Optional leading-zero blanking: define RESULT_DISPLAY_LZB_EN.
module result_display
    import result_display_pkg::*;
(
    input  logic        CLOCK_50,
    input  logic        rst_n,
    input  logic [7:0]  value,
    input  logic        signalR,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [11:0] bcd,
    output logic        busy
);

    localparam int unsigned CNT_W = $clog2(SHIFT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_CYCLES - 1);
    localparam logic [7:0] BLANK_MAG = 8'(BLANK_CODE);

    state_e            state_q, state_d;
    logic [8:0]        s1_q, s2_q;
    logic [8:0]        last_conv_q, last_conv_d;
    logic              sign_q, sign_d;
    logic              conv_valid_q, conv_valid_d;
    logic [19:0]       shreg_q, shreg_d;
    logic [19:0]       adj;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [11:0]       bcd_q, bcd_d;
    logic [6:0]        hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d, hex3_q, hex3_d;
    logic [6:0]        seg_u, seg_t, seg_h;
    logic              stable;

    assign stable = (s1_q == s2_q);

    seg7_decode u_dec_units (
        .digit_i (shreg_q[11:8]),
        .seg_o   (seg_u)
    );

    seg7_decode u_dec_tens (
        .digit_i (shreg_q[15:12]),
        .seg_o   (seg_t)
    );

    seg7_decode u_dec_hundreds (
        .digit_i (shreg_q[19:16]),
        .seg_o   (seg_h)
    );

    always_comb begin
        state_d      = state_q;
        last_conv_d  = last_conv_q;
        sign_d       = sign_q;
        conv_valid_d = conv_valid_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        bcd_d        = bcd_q;
        hex0_d       = hex0_q;
        hex1_d       = hex1_q;
        hex2_d       = hex2_q;
        hex3_d       = hex3_q;

        // Add-3 correction on each BCD nibble ahead of the shift.
        adj = shreg_q;
        for (int i = 0; i < 3; i++) begin
            if (shreg_q[8+4*i +: 4] >= 4'd5) begin
                adj[8+4*i +: 4] = shreg_q[8+4*i +: 4] + 4'd3;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (stable && (!conv_valid_q || (s2_q != last_conv_q))) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                last_conv_d = s2_q;
                sign_d      = s2_q[8];
                shreg_d     = {12'b0, s2_q[7:0]};
                cnt_d       = '0;
                state_d     = SHIFT;
            end
            SHIFT: begin
                shreg_d = adj << 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d        = shreg_q[19:8];
                conv_valid_d = 1'b1;
                state_d      = IDLE;
                if (last_conv_q[7:0] >= BLANK_MAG) begin
                    hex0_d = SEG_BLANK;
                    hex1_d = SEG_BLANK;
                    hex2_d = SEG_BLANK;
                    hex3_d = SEG_BLANK;
                end else begin
                    hex0_d = seg_u;
                    hex1_d = seg_t;
                    hex2_d = seg_h;
`ifdef RESULT_DISPLAY_LZB_EN
                    if (shreg_q[19:16] == 4'd0) begin
                        hex2_d = SEG_BLANK;
                        if (shreg_q[15:12] == 4'd0) begin
                            hex1_d = SEG_BLANK;
                        end
                    end
`endif
                    // Negative zero shows no minus sign.
                    hex3_d = (sign_q && (last_conv_q[7:0] != 8'd0)) ? SEG_MINUS : SEG_BLANK;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            s1_q         <= '0;
            s2_q         <= '0;
            last_conv_q  <= '0;
            sign_q       <= 1'b0;
            conv_valid_q <= 1'b0;
            shreg_q      <= '0;
            cnt_q        <= '0;
            bcd_q        <= '0;
            hex0_q       <= SEG_BLANK;
            hex1_q       <= SEG_BLANK;
            hex2_q       <= SEG_BLANK;
            hex3_q       <= SEG_BLANK;
        end else begin
            state_q      <= state_d;
            s1_q         <= {signalR, value};
            s2_q         <= s1_q;
            last_conv_q  <= last_conv_d;
            sign_q       <= sign_d;
            conv_valid_q <= conv_valid_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            bcd_q        <= bcd_d;
            hex0_q       <= hex0_d;
            hex1_q       <= hex1_d;
            hex2_q       <= hex2_d;
            hex3_q       <= hex3_d;
        end
    end

    assign HEX0 = hex0_q;
    assign HEX1 = hex1_q;
    assign HEX2 = hex2_q;
    assign HEX3 = hex3_q;
    assign bcd  = bcd_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_result_display.sv
// Self-checking bench for result_display: directed cases with literal
// expectations plus randomized holds checked against a decimal-arithmetic model.
module tb_result_display;

    localparam int SETTLE = 26;

    logic        clk;
    logic        rst_n;
    logic [7:0]  value;
    logic        signalR;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3;
    logic [11:0] bcd;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int chg_cyc = 0;

    result_display dut (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .value    (value),
        .signalR  (signalR),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .bcd      (bcd),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [6:0] seg_of(int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected outputs for a result held long enough to be fully displayed.
    task automatic model(input int v, input logic s, output logic [11:0] eb,
                         output logic [6:0] e0, output logic [6:0] e1,
                         output logic [6:0] e2, output logic [6:0] e3);
        int h, t, u;
        h  = v / 100;
        t  = (v / 10) % 10;
        u  = v % 10;
        eb = {4'(h), 4'(t), 4'(u)};
        if (v >= 200) begin
            e0 = 7'h7f; e1 = 7'h7f; e2 = 7'h7f; e3 = 7'h7f;
        end else begin
            e0 = seg_of(u);
            e1 = seg_of(t);
            e2 = seg_of(h);
`ifdef RESULT_DISPLAY_LZB_EN
            if (h == 0) e2 = 7'h7f;
            if (h == 0 && t == 0) e1 = 7'h7f;
`endif
            e3 = (s && v != 0) ? 7'b0111111 : 7'h7f;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] v, input logic s);
        value   = v;
        signalR = s;
        chg_cyc = cyc;
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string name);
        int n = 0;
        while (busy !== lvl && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, 32'(busy), 32'(lvl));
    endtask

    task automatic check_model(input string tag);
        logic [11:0] eb;
        logic [6:0]  e0, e1, e2, e3;
        model(int'(value), signalR, eb, e0, e1, e2, e3);
        chk({tag, "_bcd"}, 32'(bcd), 32'(eb));
        chk({tag, "_hex0"}, 32'(HEX0), 32'(e0));
        chk({tag, "_hex1"}, 32'(HEX1), 32'(e1));
        chk({tag, "_hex2"}, 32'(HEX2), 32'(e2));
        chk({tag, "_hex3"}, 32'(HEX3), 32'(e3));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Continuous compare once the input has been held long enough to settle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (cyc - chg_cyc) >= SETTLE) begin
            check_model("settled");
        end
    end

    initial begin
        int busy_rises;
        logic prev_busy;
        logic [7:0] rv;

        rst_n   = 1'b0;
        value   = 8'd0;
        signalR = 1'b0;
        tick(3);
        chk("rst_hex0", 32'(HEX0), 32'h7f);
        chk("rst_hex1", 32'(HEX1), 32'h7f);
        chk("rst_hex2", 32'(HEX2), 32'h7f);
        chk("rst_hex3", 32'(HEX3), 32'h7f);
        chk("rst_bcd", 32'(bcd), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n   = 1'b1;
        chg_cyc = cyc;
        tick(14);

        chk("zero_bcd", 32'(bcd), 32'h000);
        chk("zero_hex0", 32'(HEX0), 32'b1000000);
        chk("zero_hex3", 32'(HEX3), 32'h7f);
`ifdef RESULT_DISPLAY_LZB_EN
        chk("zero_hex1", 32'(HEX1), 32'h7f);
        chk("zero_hex2", 32'(HEX2), 32'h7f);
`else
        chk("zero_hex1", 32'(HEX1), 32'b1000000);
        chk("zero_hex2", 32'(HEX2), 32'b1000000);
`endif

        // Each directed value is checked exactly 12 edges after it is first sampled.
        drive(8'd123, 1'b1);
        tick(13);
        chk("n123_bcd", 32'(bcd), 32'h123);
        chk("n123_hex2", 32'(HEX2), 32'b1111001);
        chk("n123_hex1", 32'(HEX1), 32'b0100100);
        chk("n123_hex0", 32'(HEX0), 32'b0110000);
        chk("n123_hex3", 32'(HEX3), 32'b0111111);

        drive(8'd199, 1'b0);
        tick(13);
        chk("p199_bcd", 32'(bcd), 32'h199);
        chk("p199_hex2", 32'(HEX2), 32'b1111001);
        chk("p199_hex1", 32'(HEX1), 32'b0010000);
        chk("p199_hex0", 32'(HEX0), 32'b0010000);

        drive(8'd200, 1'b0);
        tick(13);
        chk("b200_bcd", 32'(bcd), 32'h200);
        chk("b200_hex", 32'({HEX3, HEX2, HEX1, HEX0}), 32'h0fffffff);

        drive(8'd255, 1'b1);
        tick(13);
        chk("b255_bcd", 32'(bcd), 32'h255);
        chk("b255_hex", 32'({HEX3, HEX2, HEX1, HEX0}), 32'h0fffffff);

        drive(8'd0, 1'b1);
        tick(13);
        chk("negzero_bcd", 32'(bcd), 32'h000);
        chk("negzero_hex3", 32'(HEX3), 32'h7f);
        chk("negzero_hex0", 32'(HEX0), 32'b1000000);

        // Glitch rejection: toggling every cycle must never start a conversion.
        drive(8'd7, 1'b0);
        tick(14);
        busy_rises = 0;
        for (int i = 0; i < 50; i++) begin
            drive((i % 2 == 0) ? 8'd5 : 8'd9, 1'b0);
            tick(1);
            if (busy !== 1'b0) busy_rises++;
        end
        chk("toggle_no_busy", 32'(busy_rises), 32'd0);
        busy_rises = 0;
        prev_busy  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (busy === 1'b1 && prev_busy === 1'b0) busy_rises++;
            prev_busy = busy;
        end
        chk("toggle_one_conv", 32'(busy_rises), 32'd1);
        chk("toggle_bcd", 32'(bcd), 32'h009);

        // Input change during SHIFT is deferred to a second conversion.
        drive(8'd42, 1'b0);
        wait_busy(1'b1, 20, "mid_start42");
        tick(5);
        drive(8'd77, 1'b0);
        wait_busy(1'b0, 30, "mid_done42");
        chk("mid_bcd42", 32'(bcd), 32'h042);
        wait_busy(1'b1, 30, "mid_start77");
        wait_busy(1'b0, 30, "mid_done77");
        chk("mid_bcd77", 32'(bcd), 32'h077);

        // Asynchronous reset in the middle of SHIFT.
        drive(8'd150, 1'b1);
        wait_busy(1'b1, 20, "arst_start");
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_hex", 32'({HEX3, HEX2, HEX1, HEX0}), 32'h0fffffff);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_bcd", 32'(bcd), 32'h000);
        tick(2);
        @(negedge clk);
        rst_n   = 1'b1;
        chg_cyc = cyc;
        tick(SETTLE + 2);

        // Randomized holds: short holds stress deferral, long holds are checked settled.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0: rv = 8'd0;
                1: rv = 8'd199;
                2: rv = 8'd200;
                3: rv = 8'(200 + $urandom_range(1, 55));
                default: rv = 8'($urandom_range(0, 255));
            endcase
            drive(rv, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) begin
                tick($urandom_range(1, 5));
            end else begin
                tick($urandom_range(SETTLE + 1, SETTLE + 14));
            end
        end
        tick(SETTLE + 4);
        check_model("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
